// File: rtl/alu_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_buffer
// Purpose  : First-word fall-through FIFO for ALU results and flags, with
//            sticky overflow/carry indicators and a saturating retire counter.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [DATA_WIDTH-1:0]     in_result_i,
    input  logic                      in_zero_i,
    input  logic                      in_overflow_i,
    input  logic                      in_carry_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [DATA_WIDTH-1:0]     out_result_o,
    output logic [2:0]                out_flags_o,
    input  logic                      clear_sticky_i,
    output logic                      sticky_ovf_o,
    output logic                      sticky_carry_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic [15:0]               retired_o
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_EW = DATA_WIDTH + 3;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    // Each entry packs {carry, overflow, zero, result}
    logic [c_EW-1:0]  r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             r_sticky_ovf;
    logic             r_sticky_carry;
    logic [15:0]      r_retired;

    logic             w_push;
    logic             w_pop;
    logic [c_EW-1:0]  w_head;

    assign in_ready_o  = (r_count != c_FULL);
    assign out_valid_o = (r_count != '0);
    assign w_push      = in_valid_i && in_ready_o;
    assign w_pop       = out_valid_o && out_ready_i;

    assign w_head       = r_mem[r_rd_ptr];
    assign out_result_o = w_head[DATA_WIDTH-1:0];
    assign out_flags_o  = w_head[c_EW-1 -: 3];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= {in_carry_i, in_overflow_i, in_zero_i, in_result_i};
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A setting push takes priority over a simultaneous clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sticky_ovf   <= 1'b0;
            r_sticky_carry <= 1'b0;
        end else begin
            if (w_push && in_overflow_i) begin
                r_sticky_ovf <= 1'b1;
            end else if (clear_sticky_i) begin
                r_sticky_ovf <= 1'b0;
            end
            if (w_push && in_carry_i) begin
                r_sticky_carry <= 1'b1;
            end else if (clear_sticky_i) begin
                r_sticky_carry <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_retired <= '0;
        end else if (w_pop && (r_retired != 16'hFFFF)) begin
            r_retired <= r_retired + 16'd1;
        end
    end

    assign sticky_ovf_o   = r_sticky_ovf;
    assign sticky_carry_o = r_sticky_carry;
    assign count_o        = r_count;
    assign retired_o      = r_retired;

endmodule
`default_nettype wire
